microcode_sequencer: RTL
========================

MICROCODE_SEQUENCER -- requirements
Module: microcode_sequencer

Interface
REQ-001 The block SHALL expose these parameters:
- OP_W, 8, opcode width
- FLAG_W, 4, flag input width
- CW_W, 32, control word width
- STEP_W, 4, microstep counter width
- EXT_PAGES, 2, number of step-extension pages (>=2)
- START_PAUSED, 0, 1 = leave reset in PAUSED
REQ-002 EXT_W SHALL be clog2(EXT_PAGES); ROM_AW SHALL be EXT_W+FLAG_W+OP_W+STEP_W.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 The block SHALL expose these ports:
- clk, in, 1, rising-edge clock
- rst, in, 1, synchronous active-high reset
- opcode, in, OP_W, current instruction register value
- flags, in, FLAG_W, ALU flags
- rom_data, in, CW_W, microcode ROM word, combinational read
- step_resetn, in, 1, active-low end-of-instruction request from the current control word
- step_extn, in, 1, active-low jump to the next extension page
- halt, in, 1, halt request from the current control word
- brk, in, 1, breakpoint request from the current control word
- single_step, in, 1, mode: pause after every microstep
- step_req, in, 1, advance one microstep while PAUSED (rising edge)
- cont_req, in, 1, resume RUN from PAUSED (level)
- rom_addr, out, ROM_AW, {ext, flags, opcode, step}
- control_word, out, CW_W, rom_data when ctrlen, else 0
- ctrlen, out, 1, control word is live this cycle
- step, out, STEP_W, current microstep
- ext, out, EXT_W, current extension page
- fetch, out, 1, high when step==0 and ext==0
- halted, out, 1, state==HALTED
- paused, out, 1, state==PAUSED
- overrun, out, 1, sticky step or page overflow

Function
REQ-005 States SHALL be RUN, STEP, PAUSED and HALTED.
REQ-006 ctrlen SHALL be 1 in RUN and in STEP, and 0 otherwise.
REQ-007 rom_addr, control_word and fetch SHALL be combinational from the registered state, with zero-cycle latency.
REQ-008 Advance rule: on a clk edge with ctrlen=1, the block SHALL take the first matching case:
- step_resetn=0 -> step=0, ext=0
- else step_extn=0 -> ext+1, step=0
- else -> step+1
REQ-009 When step_resetn=0 and step_extn=0 occur together, step_resetn SHALL win.
REQ-010 When step is all-ones and the advance rule selects step+1, step SHALL wrap to 0, ext SHALL be unchanged, and overrun SHALL set.
REQ-011 When ext=EXT_PAGES-1 and step_extn=0 is selected, ext SHALL hold, step SHALL become 0, and overrun SHALL set.
REQ-012 RUN transitions, evaluated on the same edge as the advance:
- halt=1 -> HALTED
- else brk=1 -> PAUSED
- else single_step=1 -> PAUSED
- else stay in RUN
REQ-013 When halt and brk are both high, halt SHALL take priority.
REQ-014 The control word that asserts halt or brk SHALL be executed (ctrlen=1 that cycle), and the advance SHALL still occur.
REQ-015 STEP SHALL last exactly one cycle, apply the advance rule, then go to HALTED if halt=1, otherwise to PAUSED.
REQ-016 PAUSED SHALL hold step and ext.
REQ-017 In PAUSED, cont_req=1 SHALL go to RUN next cycle.
REQ-018 In PAUSED, a detected step_req rising edge (step_req=1 with registered previous value 0) SHALL go to STEP next cycle.
REQ-019 When cont_req and a step_req edge coincide, cont_req SHALL win.
REQ-020 The step_req previous-value register SHALL update every cycle in all states.
REQ-021 step_req edges seen outside PAUSED SHALL be ignored and SHALL NOT be queued.
REQ-022 HALTED SHALL be exited only by rst; all other inputs SHALL be ignored in HALTED.
REQ-023 overrun SHALL be cleared only by rst.

Reset
REQ-024 With rst=1 at a clk edge, the block SHALL set step=0, ext=0, overrun=0, and the step_req previous-value register=1, so that a step_req held high through reset does not trigger.
REQ-025 On reset the state SHALL become PAUSED if START_PAUSED=1, otherwise RUN.
REQ-026 Reset SHALL override every other input, including reset asserted mid-instruction, in STEP, or in HALTED.
REQ-027 During rst, control_word SHALL reflect the pre-edge state.
REQ-028 After the reset edge, with START_PAUSED=0, the block SHALL have ctrlen=1, fetch=1 and rom_addr={0,flags,opcode,0}.

Verification
REQ-029 Normal sequence: opcode=0x3C, flags=0x5; run 3 cycles with step_resetn=1, then one cycle with step_resetn=0 -> rom_addr steps 0x053C0..0x053C3, then returns to step 0; fetch=1 on cycles 0 and 4.
REQ-030 Extension page: step_extn=0 at step 7 -> next ext=1, step=0 (rom_addr bit 16 set); a following step_resetn=0 -> ext=0, step=0; with step_resetn=0 and step_extn=0 together -> ext=0.
REQ-031 Overflow: 16 advances with no resets -> step wraps 15->0 and overrun=1; with ext=1 and step_extn=0 -> ext stays 1 and overrun stays 1 until rst.
REQ-032 Break and single step: brk=1 at step 2 -> that control_word is non-zero, then paused=1 with step=3 and control_word=0; a step_req pulse -> exactly one cycle with ctrlen=1 and step 3->4; step_req held high -> no further steps; cont_req=1 -> RUN.
REQ-033 Halt priority: halt=1 and brk=1 together -> halted=1, ctrlen=0; cont_req and step_req are then ignored; rst -> RUN with step=0.
REQ-034 Reset mid-operation: rst at step 5, ext=1, state PAUSED, START_PAUSED=1 -> next cycle step=0, ext=0, paused=1, overrun=0, and step_req held high does not advance.

Source files
------------

// File: rtl/microcode_sequencer.sv
// -----------------------------------------------------------------------------
// microcode_sequencer
//
// Steps a microcode ROM through the microsteps of the current instruction.
// The ROM is addressed by {ext, flags, opcode, step}. The ROM word read back
// is gated onto control_word only while the sequencer is executing. That
// happens in RUN, and for exactly one cycle in STEP. The current word can
// end the instruction (step_resetn), jump to the next extension page
// (step_extn), halt the machine (halt), or request a breakpoint (brk).
// A single-step mode and a paused state allow the machine to be walked one
// microstep at a time.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   opcode       current instruction register value
//   flags        ALU flags
//   rom_data     microcode ROM word (combinational read of rom_addr)
//   step_resetn  active-low end-of-instruction request from the control word
//   step_extn    active-low jump to the next extension page
//   halt         halt request from the control word
//   brk          breakpoint request from the control word
//   single_step  mode: pause after every microstep
//   step_req     advance one microstep while paused (rising edge)
//   cont_req     resume RUN from PAUSED (level)
//   rom_addr     {ext, flags, opcode, step}
//   control_word rom_data while ctrlen, else 0
//   ctrlen       control word is live this cycle
//   step         current microstep
//   ext          current extension page
//   fetch        step == 0 and ext == 0
//   halted       machine is halted
//   paused       machine is paused
//   overrun      sticky step or page overflow, cleared only by rst
// -----------------------------------------------------------------------------
module microcode_sequencer #(
    parameter int OP_W         = 8,
    parameter int FLAG_W       = 4,
    parameter int CW_W         = 32,
    parameter int STEP_W       = 4,
    parameter int EXT_PAGES    = 2,
    parameter int START_PAUSED = 0,
    localparam int EXT_W       = $clog2(EXT_PAGES),
    localparam int ROM_AW      = EXT_W + FLAG_W + OP_W + STEP_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [OP_W-1:0]   opcode,
    input  logic [FLAG_W-1:0] flags,
    input  logic [CW_W-1:0]   rom_data,
    input  logic              step_resetn,
    input  logic              step_extn,
    input  logic              halt,
    input  logic              brk,
    input  logic              single_step,
    input  logic              step_req,
    input  logic              cont_req,
    output logic [ROM_AW-1:0] rom_addr,
    output logic [CW_W-1:0]   control_word,
    output logic              ctrlen,
    output logic [STEP_W-1:0] step,
    output logic [EXT_W-1:0]  ext,
    output logic              fetch,
    output logic              halted,
    output logic              paused,
    output logic              overrun
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_STEP,
        ST_PAUSED,
        ST_HALTED
    } state_t;

    localparam state_t            RESET_STATE = (START_PAUSED != 0) ? ST_PAUSED : ST_RUN;
    localparam logic [EXT_W-1:0]  EXT_LAST    = EXT_W'(EXT_PAGES - 1);
    localparam logic [EXT_W-1:0]  EXT_ONE     = EXT_W'(1);
    localparam logic [STEP_W-1:0] STEP_ONE    = STEP_W'(1);

    state_t            state;
    state_t            state_nxt;
    logic [STEP_W-1:0] step_nxt;
    logic [EXT_W-1:0]  ext_nxt;
    logic              overrun_nxt;
    logic              step_req_q;
    logic              step_req_edge;

    // Previous step_req resets to 1 so a request held high through reset
    // is not mistaken for a fresh edge.
    assign step_req_edge = step_req & ~step_req_q;

    // State, microstep, page and sticky overflow registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RESET_STATE;
            step       <= '0;
            ext        <= '0;
            overrun    <= 1'b0;
            step_req_q <= 1'b1;
        end else begin
            state      <= state_nxt;
            step       <= step_nxt;
            ext        <= ext_nxt;
            overrun    <= overrun_nxt;
            step_req_q <= step_req;
        end
    end

    // Advance rule and state transitions
    always_comb begin
        state_nxt   = state;
        step_nxt    = step;
        ext_nxt     = ext;
        overrun_nxt = overrun;

        // The word that executes this cycle (RUN or the single STEP cycle)
        // always advances, even when it also requests halt or brk.
        if (ctrlen) begin
            if (!step_resetn) begin
                step_nxt = '0;
                ext_nxt  = '0;
            end else if (!step_extn) begin
                step_nxt = '0;
                if (ext == EXT_LAST) begin
                    overrun_nxt = 1'b1;
                end else begin
                    ext_nxt = ext + EXT_ONE;
                end
            end else begin
                step_nxt = step + STEP_ONE;
                if (&step) begin
                    overrun_nxt = 1'b1;
                end
            end
        end

        unique case (state)
            ST_RUN: begin
                if (halt) begin
                    state_nxt = ST_HALTED;
                end else if (brk || single_step) begin
                    state_nxt = ST_PAUSED;
                end
            end
            ST_STEP: begin
                state_nxt = halt ? ST_HALTED : ST_PAUSED;
            end
            ST_PAUSED: begin
                if (cont_req) begin
                    state_nxt = ST_RUN;
                end else if (step_req_edge) begin
                    state_nxt = ST_STEP;
                end
            end
            ST_HALTED: begin
                state_nxt = ST_HALTED;
            end
            default: begin
                state_nxt = RESET_STATE;
            end
        endcase
    end

    // Outputs decoded straight from the registered state
    assign ctrlen       = (state == ST_RUN) || (state == ST_STEP);
    assign halted       = (state == ST_HALTED);
    assign paused       = (state == ST_PAUSED);
    assign fetch        = (step == '0) && (ext == '0);
    assign rom_addr     = {ext, flags, opcode, step};
    assign control_word = ctrlen ? rom_data : '0;

endmodule
